tile_area_mapper: RTL and testbench
===================================

// Module: tile_area_mapper
// PURPOSE
//  Pipelined, parametrised successor of the combinational pixel->tile mapper.
//  Maps a VGA scan coordinate (col_addr,row_addr) onto a GRIDxGRID board of square
//  tiles, with a configurable origin and inter-tile gap. Outputs the tile area code,
//  the intra-tile ROM address and an outline flag with fixed 2-stage latency.
//  Sits between the VGA timing generator and the tile-bitmap ROM / colour mux.
// PARAMETERS
//  GRID   4    tiles per row/column; area codes 1..GRID*GRID
//  TILE   120  tile edge in pixels; intra-tile address = ly*TILE+lx
//  GAP    0    background pixels between adjacent tiles (area 0 there)
//  ORG_X  0    column of top-left pixel of tile 1
//  ORG_Y  0    row of top-left pixel of tile 1
//  EDGE   2    outline thickness in pixels, for edge_o (0 disables)
//  Derived localparams: PITCH=TILE+GAP; AREA_W=$clog2(GRID*GRID+1);
//  ADDR_W=$clog2(TILE*TILE); LOC_W=$clog2(TILE)
// PORTS
//  clk        in   1       pixel clock
//  rst_n      in   1       asynchronous reset, active low
//  ce         in   1       pipeline advance enable (pixel strobe)
//  in_valid   in   1       coordinate on col_addr/row_addr is valid
//  col_addr   in   10      scan column
//  row_addr   in   9       scan row
//  out_valid  out  1       stage-2 outputs valid
//  area       out  AREA_W  1..GRID*GRID row-major from top-left; 0 = outside/gap
//  addr       out  ADDR_W  intra-tile address; 0 when area==0
//  local_x    out  LOC_W   column within tile; 0 when area==0
//  local_y    out  LOC_W   row within tile; 0 when area==0
//  edge_o     out  1       pixel within EDGE px of its tile border; 0 when area==0
// BEHAVIOUR
//  - Reset (async assert, sync release): every register and output = 0.
//  - Pipeline moves only when ce=1; ce=0 holds all stage regs and outputs.
//  - Latency: exactly 2 ce-qualified cycles from input sample to outputs.
//  - out_valid = in_valid delayed by 2 ce cycles; outputs with out_valid=0 are
//    don't-care for consumers but are still computed, never X.
//  - Stage 1 (per axis, no divider, no loop): dx=col_addr-ORG_X in 11-bit signed;
//    parallel compare of dx against k*PITCH (k=0..GRID-1, generate) picks tile
//    index tx and offset ox=dx-tx*PITCH; axis in-range iff dx>=0, tx<GRID,
//    ox<TILE. Same for y. Register tx,ty,ox,oy,hit=inx&iny.
//  - Stage 2: area = hit ? ty*GRID+tx+1 : 0; addr = hit ? oy*TILE+ox : 0
//    (multiply by constant, full ADDR_W, no truncation for legal TILE);
//    edge_o = hit & (ox<EDGE | oy<EDGE | ox>=TILE-EDGE | oy>=TILE-EDGE).
//  - Boundaries: coordinate = ORG+GRID*PITCH-GAP-1 is last in-tile pixel;
//    negative offsets, gap pixels, coords beyond grid -> all outputs 0 (valid kept).
//  - in_valid=0 while ce=1 pushes a bubble; data regs still load.
//  - rst_n low mid-stream: pipeline flushed, out_valid=0 in same cycle;
//    after release first out_valid at 2nd ce cycle with in_valid=1.
//  - Elaboration check: GRID*PITCH+ORG must fit coordinate widths, else $error.
// STRUCTURE
//  - Shared pkg tile_pkg: GRID/TILE defaults, AREA_W/ADDR_W helper functions,
//    area code constant AREA_NONE=0.
//  - One sub-module tile_axis_split (param GRID,TILE,GAP,ORG,W): stage-1 range
//    compare + offset, instantiated once for x, once for y.
//  - Top holds valid pipe, stage-2 multiply/area/edge logic.
// TESTING (defaults unless stated; ce=1)
//  1 (0,0) valid -> 2 cycles later area=1, addr=0, edge_o=1, out_valid=1.
//  2 col=121,row=245 -> area=10, lx=1, ly=5, addr=601, edge_o=1.
//  3 (479,479) -> area=16, addr=14399; (480,0) and (0,480) -> area=0, addr=0.
//  4 GAP=8,ORG_X=16: col=135 -> area=1,lx=119; col=136..143 -> area=0;
//    col=144 -> area=2, lx=0; col=15 -> area=0.
//  5 full 640x480 raster with random ce gaps vs. reference model: every output
//    matches model delayed 2 ce cycles; ce=0 holds outputs stable.
//  6 rst_n pulsed low mid-line -> outputs 0 immediately; resume, first
//    out_valid exactly 2 ce cycles after first post-reset in_valid.

Source files
------------

// File: rtl/tile_area_mapper_pkg.sv
// Shared definitions for the tile area mapper slice.
// Holds the default board geometry, the scan coordinate widths, the "no tile"
// area code, and width helpers that the interface, the axis splitter and the
// top use to size their buses.
package tile_pkg;

  localparam int unsigned GRID_DEF  = 4;
  localparam int unsigned TILE_DEF  = 120;
  localparam int unsigned AREA_NONE = 0;
  localparam int unsigned COL_W     = 10;
  localparam int unsigned ROW_W     = 9;

  // Area codes run 1..grid*grid, with 0 reserved for background.
  function automatic int unsigned area_w(input int unsigned grid);
    return $clog2(grid * grid + 1);
  endfunction

  function automatic int unsigned addr_w(input int unsigned tile);
    return $clog2(tile * tile);
  endfunction

  function automatic int unsigned loc_w(input int unsigned tile);
    return $clog2(tile);
  endfunction

  function automatic int unsigned idx_w(input int unsigned grid);
    return (grid > 1) ? $clog2(grid) : 1;
  endfunction

endpackage

// File: rtl/tile_area_mapper_if.sv
// Coordinate-in / tile-info-out bundle of the tile area mapper.
//   ce, in_valid, col_addr, row_addr        : from the VGA timing side
//   out_valid, area, addr, local_x, local_y,
//   edge_o                                  : to the tile ROM / colour mux
// master = producer of coordinates, slave = the mapper.
interface tile_area_mapper_if
  import tile_pkg::*;
#(
  parameter int unsigned GRID = GRID_DEF,
  parameter int unsigned TILE = TILE_DEF
) ();

  localparam int unsigned AREA_W = area_w(GRID);
  localparam int unsigned ADDR_W = addr_w(TILE);
  localparam int unsigned LOC_W  = loc_w(TILE);

  logic              ce;
  logic              in_valid;
  logic [COL_W-1:0]  col_addr;
  logic [ROW_W-1:0]  row_addr;
  logic              out_valid;
  logic [AREA_W-1:0] area;
  logic [ADDR_W-1:0] addr;
  logic [LOC_W-1:0]  local_x;
  logic [LOC_W-1:0]  local_y;
  logic              edge_o;

  modport master (
    output ce, in_valid, col_addr, row_addr,
    input  out_valid, area, addr, local_x, local_y, edge_o
  );

  modport slave (
    input  ce, in_valid, col_addr, row_addr,
    output out_valid, area, addr, local_x, local_y, edge_o
  );

endinterface

// File: rtl/tile_area_mapper_axis_split.sv
// One axis of the stage-1 mapping: locates a scan coordinate on the tile grid.
//   coord    : scan coordinate (W bits)
//   idx      : tile index along this axis
//   ofs      : offset inside that tile (meaningful only when in_range)
//   in_range : coordinate lies inside a tile (not before origin, not in a gap,
//              not past the last tile)
// Purely combinational; the top registers the results.
module tile_axis_split
  import tile_pkg::*;
#(
  parameter int unsigned GRID = GRID_DEF,
  parameter int unsigned TILE = TILE_DEF,
  parameter int unsigned GAP  = 0,
  parameter int unsigned ORG  = 0,
  parameter int unsigned W    = COL_W
) (
  input  logic [W-1:0]            coord,
  output logic [idx_w(GRID)-1:0]  idx,
  output logic [loc_w(TILE)-1:0]  ofs,
  output logic                    in_range
);

  localparam int unsigned PITCH = TILE + GAP;
  localparam int unsigned DW    = W + 1;
  localparam int unsigned IDX_W = idx_w(GRID);
  localparam int unsigned LOC_W = loc_w(TILE);

  // The last in-tile pixel (ORG + GRID*PITCH - GAP - 1) must be addressable.
  if (ORG + GRID * PITCH - GAP > (1 << W)) begin : g_fit_check
    $error("tile_axis_split: grid does not fit a %0d-bit coordinate", W);
  end

  // One extra bit so a coordinate left of the origin shows up as negative.
  logic [DW-1:0] dx;
  logic          neg;
  assign dx  = {1'b0, coord} - DW'(ORG);
  assign neg = dx[DW-1];

  // Thermometer compare against every tile start, folded into a priority
  // chain so the highest passed start selects both index and base.
  logic [IDX_W-1:0] idx_c  [GRID];
  logic [DW-1:0]    base_c [GRID];

  assign idx_c[0]  = '0;
  assign base_c[0] = '0;

  for (genvar k = 1; k < GRID; k++) begin : g_cmp
    localparam logic [DW-1:0] BASE = DW'(k * PITCH);
    logic ge;
    assign ge        = !neg && (dx >= BASE);
    assign idx_c[k]  = ge ? IDX_W'(k) : idx_c[k-1];
    assign base_c[k] = ge ? BASE : base_c[k-1];
  end

  logic [DW-1:0] off;
  assign off      = dx - base_c[GRID-1];
  assign in_range = !neg && (off < DW'(TILE));
  assign idx      = idx_c[GRID-1];
  assign ofs      = off[LOC_W-1:0];

endmodule

// File: rtl/tile_area_mapper.sv
// Two-stage pipelined pixel -> tile mapper.
//   clk, rst_n : pixel clock, asynchronous active-low reset
//   bus        : slave side of tile_area_mapper_if (ce strobe, coordinate in,
//                area code / intra-tile address / local x,y / outline flag out)
// Stage 1 splits each axis into tile index + offset; stage 2 forms the area
// code, the ROM address and the outline flag. Everything advances only on ce.
module tile_area_mapper
  import tile_pkg::*;
#(
  parameter int unsigned GRID  = GRID_DEF,
  parameter int unsigned TILE  = TILE_DEF,
  parameter int unsigned GAP   = 0,
  parameter int unsigned ORG_X = 0,
  parameter int unsigned ORG_Y = 0,
  parameter int unsigned EDGE  = 2
) (
  input logic               clk,
  input logic               rst_n,
  tile_area_mapper_if.slave bus
);

  localparam int unsigned AREA_W = area_w(GRID);
  localparam int unsigned ADDR_W = addr_w(TILE);
  localparam int unsigned LOC_W  = loc_w(TILE);
  localparam int unsigned IDX_W  = idx_w(GRID);

  logic [IDX_W-1:0] tx, ty;
  logic [LOC_W-1:0] ox, oy;
  logic             inx, iny;

  tile_axis_split #(
    .GRID(GRID), .TILE(TILE), .GAP(GAP), .ORG(ORG_X), .W(COL_W)
  ) u_x (
    .coord(bus.col_addr), .idx(tx), .ofs(ox), .in_range(inx)
  );

  tile_axis_split #(
    .GRID(GRID), .TILE(TILE), .GAP(GAP), .ORG(ORG_Y), .W(ROW_W)
  ) u_y (
    .coord(bus.row_addr), .idx(ty), .ofs(oy), .in_range(iny)
  );

  // Stage 1 registers
  logic             v1_q, hit_q;
  logic [IDX_W-1:0] tx_q, ty_q;
  logic [LOC_W-1:0] ox_q, oy_q;

  // Stage 2 next values
  logic [AREA_W-1:0] area_n;
  logic [ADDR_W-1:0] addr_n;
  logic [LOC_W-1:0]  lx_n, ly_n;
  logic              edge_n;

  always_comb begin
    area_n = AREA_W'(AREA_NONE);
    addr_n = '0;
    lx_n   = '0;
    ly_n   = '0;
    edge_n = 1'b0;
    if (hit_q) begin
      area_n = AREA_W'(32'(ty_q) * GRID + 32'(tx_q) + 1);
      addr_n = ADDR_W'(32'(oy_q) * TILE + 32'(ox_q));
      lx_n   = ox_q;
      ly_n   = oy_q;
      // Far-side test written as ofs+EDGE >= TILE so EDGE > TILE cannot wrap.
      edge_n = (32'(ox_q) < EDGE) || (32'(oy_q) < EDGE) ||
               (32'(ox_q) + EDGE >= TILE) || (32'(oy_q) + EDGE >= TILE);
    end
  end

  // Stage 2 registers
  logic              v2_q, edge_q;
  logic [AREA_W-1:0] area_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LOC_W-1:0]  lx_q, ly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      hit_q  <= 1'b0;
      tx_q   <= '0;
      ty_q   <= '0;
      ox_q   <= '0;
      oy_q   <= '0;
      v2_q   <= 1'b0;
      area_q <= '0;
      addr_q <= '0;
      lx_q   <= '0;
      ly_q   <= '0;
      edge_q <= 1'b0;
    end else if (bus.ce) begin
      v1_q   <= bus.in_valid;
      hit_q  <= inx & iny;
      tx_q   <= tx;
      ty_q   <= ty;
      ox_q   <= ox;
      oy_q   <= oy;
      v2_q   <= v1_q;
      area_q <= area_n;
      addr_q <= addr_n;
      lx_q   <= lx_n;
      ly_q   <= ly_n;
      edge_q <= edge_n;
    end
  end

  assign bus.out_valid = v2_q;
  assign bus.area      = area_q;
  assign bus.addr      = addr_q;
  assign bus.local_x   = lx_q;
  assign bus.local_y   = ly_q;
  assign bus.edge_o    = edge_q;

endmodule

// File: tb/tb_tile_area_mapper.sv
// Scoreboard bench for tile_area_mapper. Two instances share one stimulus
// stream: dut0 with the default board, dut1 with GAP=8 and ORG_X=16. Each
// ce-qualified input pushes the reference answer for both boards; a monitor
// pops one entry per ce edge and compares the full output bundle, and checks
// that outputs hold when ce is low.
module tb_tile_area_mapper;
  import tile_pkg::*;

  localparam int unsigned AW  = area_w(4);
  localparam int unsigned ADW = addr_w(120);
  localparam int unsigned LW  = loc_w(120);

  typedef struct packed {
    logic          v;
    logic [AW-1:0] area;
    logic [ADW-1:0] addr;
    logic [LW-1:0] lx;
    logic [LW-1:0] ly;
    logic          e;
  } exp_t;

  logic             clk, rst_n;
  logic             ce, in_valid;
  logic [COL_W-1:0] col_addr;
  logic [ROW_W-1:0] row_addr;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t cur0, cur1, last0, last1;
  logic ce_s, rst_s;

  tile_area_mapper_if #(.GRID(4), .TILE(120)) if0 ();
  tile_area_mapper_if #(.GRID(4), .TILE(120)) if1 ();

  assign if0.ce = ce;       assign if1.ce = ce;
  assign if0.in_valid = in_valid; assign if1.in_valid = in_valid;
  assign if0.col_addr = col_addr; assign if1.col_addr = col_addr;
  assign if0.row_addr = row_addr; assign if1.row_addr = row_addr;

  tile_area_mapper #(
    .GRID(4), .TILE(120), .GAP(0), .ORG_X(0), .ORG_Y(0), .EDGE(2)
  ) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));

  tile_area_mapper #(
    .GRID(4), .TILE(120), .GAP(8), .ORG_X(16), .ORG_Y(0), .EDGE(2)
  ) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain division/modulo on the board geometry.
  function automatic exp_t model(input int gap, input int org_x, input int org_y,
                                 input int col, input int row, input logic v);
    exp_t r;
    int pitch, dx, dy, tx, ty, lx, ly;
    r = '0;
    r.v = v;
    pitch = 120 + gap;
    dx = col - org_x;
    dy = row - org_y;
    if (dx >= 0 && dy >= 0) begin
      tx = dx / pitch; lx = dx % pitch;
      ty = dy / pitch; ly = dy % pitch;
      if (tx < 4 && ty < 4 && lx < 120 && ly < 120) begin
        r.area = AW'(ty * 4 + tx + 1);
        r.addr = ADW'(ly * 120 + lx);
        r.lx   = LW'(lx);
        r.ly   = LW'(ly);
        r.e    = (lx < 2) || (ly < 2) || (lx >= 118) || (ly >= 118);
      end
    end
    return r;
  endfunction

  task automatic show_fail(input string name, input int d, input exp_t got, input exp_t req);
    n_fail++;
    $display("FAIL %s dut%0d: got v=%0d area=%0d addr=%0d lx=%0d ly=%0d edge=%0d, required v=%0d area=%0d addr=%0d lx=%0d ly=%0d edge=%0d",
             name, d, got.v, got.area, got.addr, got.lx, got.ly, got.e,
             req.v, req.area, req.addr, req.lx, req.ly, req.e);
  endtask

  task automatic check_pop(input int d, input exp_t got);
    exp_t req;
    n_tests++;
    if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
      n_fail++;
      $display("FAIL sb_underflow dut%0d: got an output edge, required a queued expectation", d);
    end else begin
      if (d == 0) req = sb0.pop_front();
      else        req = sb1.pop_front();
      if (got !== req) show_fail("pipe_out", d, got, req);
    end
  endtask

  // Monitor: latch ce/reset at the edge, sample outputs 1 ns later.
  always begin
    @(posedge clk);
    ce_s  = ce;
    rst_s = rst_n;
    #1;
    cur0 = {if0.out_valid, if0.area, if0.addr, if0.local_x, if0.local_y, if0.edge_o};
    cur1 = {if1.out_valid, if1.area, if1.addr, if1.local_x, if1.local_y, if1.edge_o};
    if (rst_s) begin
      if (ce_s) begin
        check_pop(0, cur0);
        check_pop(1, cur1);
      end else begin
        n_tests++;
        if (cur0 !== last0) show_fail("ce_hold", 0, cur0, last0);
        n_tests++;
        if (cur1 !== last1) show_fail("ce_hold", 1, cur1, last1);
      end
    end
    last0 = cur0;
    last1 = cur1;
  end

  task automatic drive(input logic c, input logic v, input int col, input int row);
    @(negedge clk);
    ce       = c;
    in_valid = v;
    col_addr = COL_W'(col);
    row_addr = ROW_W'(row);
    if (c) begin
      sb0.push_back(model(0, 0, 0, col, row, v));
      sb1.push_back(model(8, 16, 0, col, row, v));
    end
  endtask

  task automatic check_zero(input string name);
    exp_t g0, g1;
    g0 = {if0.out_valid, if0.area, if0.addr, if0.local_x, if0.local_y, if0.edge_o};
    g1 = {if1.out_valid, if1.area, if1.addr, if1.local_x, if1.local_y, if1.edge_o};
    n_tests++;
    if (g0 !== '0) show_fail(name, 0, g0, '0);
    n_tests++;
    if (g1 !== '0) show_fail(name, 1, g1, '0);
  endtask

  // Release at a falling edge; stage 1 holds reset zeros, which the first
  // ce edge shifts into the outputs, hence one all-zero entry up front.
  task automatic release_reset();
    repeat (3) @(negedge clk);
    sb0.delete();
    sb1.delete();
    sb0.push_back('0);
    sb1.push_back('0);
    ce    = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n    = 1'b0;
    ce       = 1'b1;
    in_valid = 1'b1;
    #1;
    check_zero("reset_mid");
    release_reset();
  endtask

  function automatic bit row_selected(input int r);
    return (r % 20 == 0) || (r % 120 == 119) || (r % 120 == 1) ||
           (r == 480) || (r == 511);
  endfunction

  initial begin
    rst_n    = 1'b0;
    ce       = 1'b0;
    in_valid = 1'b0;
    col_addr = '0;
    row_addr = '0;
    #3;
    check_zero("reset_state");
    release_reset();

    // Directed corners: origin, interior tile, last pixel, just past the grid.
    drive(1, 1, 0, 0);
    drive(1, 1, 121, 245);
    drive(0, 1, 7, 7);
    drive(1, 1, 479, 479);
    drive(1, 1, 480, 0);
    drive(1, 1, 0, 480);
    // Gap board: end of tile 1, gap pixels, start of tile 2, left of origin.
    drive(1, 1, 135, 0);
    for (int c = 136; c <= 143; c++) drive(1, 1, c, 0);
    drive(1, 1, 144, 0);
    drive(1, 1, 15, 0);
    drive(1, 0, 200, 200);
    drive(1, 1, 1023, 511);

    // Sampled raster with random ce gaps, bubbles and a mid-line reset.
    for (int r = 0; r < 512; r++) begin
      if (row_selected(r)) begin
        for (int c = 0; c < 640; c++) begin
          if (r == 240 && c == 300) reset_pulse();
          while ($urandom_range(0, 3) == 0)
            drive(0, 1'($urandom_range(0, 1)), $urandom_range(0, 1023), $urandom_range(0, 511));
          drive(1, ($urandom_range(0, 9) != 0), c, r);
        end
        drive(1, 1, $urandom_range(640, 1023), r);
      end
    end

    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    @(negedge clk);
    n_tests++;
    if (sb0.size() != 1 || sb1.size() != 1) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d/%0d pending entries, required 1/1", sb0.size(), sb1.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
